// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - state type, function codes and op-class decode for mul_acc.
// MUL_RADIX4_EN selects the 2-bit-per-cycle iteration width.
package mul_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} mul_state_t;

  // SPECIAL class
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  // SPECIAL2 class
  localparam logic [5:0] FN_MADD  = 6'h00;
  localparam logic [5:0] FN_MADDU = 6'h01;
  localparam logic [5:0] FN_MUL   = 6'h02;
  localparam logic [5:0] FN_MSUB  = 6'h04;
  localparam logic [5:0] FN_MSUBU = 6'h05;

`ifdef MUL_RADIX4_EN
  localparam int CNT_W = 4;
  localparam int STEP  = 2;
`else
  localparam int CNT_W = 5;
  localparam int STEP  = 1;
`endif

  typedef struct packed {
    logic is_mult;
    logic is_acc;
    logic is_sub;
    logic is_signed;
  } op_class_t;

  function automatic op_class_t decode_op(input logic mul_op, input logic [5:0] func);
    op_class_t c;
    c = '0;
    if (mul_op) begin
      case (func)
        FN_MADD:  c = '{1'b1, 1'b1, 1'b0, 1'b1};
        FN_MADDU: c = '{1'b1, 1'b1, 1'b0, 1'b0};
        FN_MSUB:  c = '{1'b1, 1'b1, 1'b1, 1'b1};
        FN_MSUBU: c = '{1'b1, 1'b1, 1'b1, 1'b0};
        FN_MUL:   c = '{1'b1, 1'b0, 1'b0, 1'b1};
        default:  c = '0;
      endcase
    end else begin
      case (func)
        FN_MULT:  c = '{1'b1, 1'b0, 1'b0, 1'b1};
        FN_MULTU: c = '{1'b1, 1'b0, 1'b0, 1'b0};
        default:  c = '0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - unsigned shift-add multiplier core with iteration counter.
// MUL_RADIX4_EN retires two multiplier bits per cycle using 0/1x, 2x, 3x multiples.
module mul_iter
  import mul_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        run,
  input  logic [31:0] mag_a,
  input  logic [31:0] mag_b,
  output logic [63:0] product,
  output logic        done
);

  logic [CNT_W-1:0] count;
  logic [63:0]      acc;
  logic [63:0]      m1;
  logic [31:0]      mplier;
  logic [63:0]      addend;

`ifdef MUL_RADIX4_EN
  logic [63:0] m3;

  always_comb begin
    case (mplier[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = m1;
      2'd2:    addend = {m1[62:0], 1'b0};
      default: addend = m3;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     m3 <= '0;
    else if (load) m3 <= {32'b0, mag_a} + {31'b0, mag_a, 1'b0};
    else if (run)  m3 <= m3 << STEP;
  end
`else
  always_comb addend = mplier[0] ? m1 : '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      m1     <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      m1     <= {32'b0, mag_a};
      mplier <= mag_b;
      count  <= '0;
    end else if (run) begin
      acc    <= acc + addend;
      m1     <= m1 << STEP;
      mplier <= mplier >> STEP;
      count  <= count + 1'b1;
    end
  end

  // done flags the cycle whose step is the last one, so the FSM leaves CALC on that edge
  assign done    = run & (&count);
  assign product = acc;

endmodule

// File: rtl/mul_acc.sv
// rtl/mul_acc.sv - iterative multiply/accumulate unit owning HI/LO, stalls EX while busy.
// MUL_RADIX4_EN (in mul_iter) halves the CALC phase; results are identical.
module mul_acc
  import mul_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        Start,
  input  logic        MULOp,
  input  logic        ACCEn,
  input  logic        MULSelB,
  input  logic        Flush,
  input  logic [5:0]  Func,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Stall
);

  mul_state_t  state;
  op_class_t   dec;
  logic        idle, go, is_mul3, mt_hi, mt_lo;
  logic        acc_q, sub_q, mul3_q, neg_q;
  logic [31:0] mag_a, mag_b, res_q;
  logic [63:0] prod, fixed, sum;
  logic        iter_done;

  assign dec     = decode_op(MULOp, Func);
  assign idle    = (state == S_IDLE);
  assign go      = idle & Start & ~Flush & dec.is_mult;
  assign is_mul3 = MULOp & (Func == FN_MUL);
  assign mt_hi   = idle & Start & ~MULOp & ACCEn & ~MULSelB & (Func == FN_MTHI);
  assign mt_lo   = idle & Start & ~MULOp & ACCEn & ~MULSelB & (Func == FN_MTLO);

  // Magnitudes as unsigned 32-bit: 0x80000000 negates to itself, i.e. 2^31
  assign mag_a = (dec.is_signed & A[31]) ? (~A + 32'd1) : A;
  assign mag_b = (dec.is_signed & B[31]) ? (~B + 32'd1) : B;

  mul_iter u_iter (
    .clock   (clock),
    .reset   (reset),
    .load    (go),
    .run     (state == S_CALC),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .product (prod),
    .done    (iter_done)
  );

  assign fixed = neg_q ? (~prod + 64'd1) : prod;
  assign sum   = sub_q ? ({HI, LO} - fixed) : ({HI, LO} + fixed);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      HI     <= '0;
      LO     <= '0;
      res_q  <= '0;
      acc_q  <= 1'b0;
      sub_q  <= 1'b0;
      mul3_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (Flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (mt_hi) HI <= A;
          if (mt_lo) LO <= A;
          if (go) begin
            state  <= S_CALC;
            acc_q  <= dec.is_acc;
            sub_q  <= dec.is_sub;
            mul3_q <= is_mul3;
            neg_q  <= dec.is_signed & (A[31] ^ B[31]);
          end
        end
        S_CALC: if (iter_done) state <= S_FIX;
        S_FIX: begin
          if (mul3_q) begin
            res_q <= fixed[31:0];
          end else begin
            res_q    <= '0;
            {HI, LO} <= acc_q ? sum : fixed;
          end
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    Result = '0;
    if (state == S_DONE)
      Result = res_q;
    else if (idle & Start & ~MULOp & (Func == FN_MFHI))
      Result = HI;
    else if (idle & Start & ~MULOp & (Func == FN_MFLO))
      Result = LO;
  end

  assign Stall = go | (state == S_CALC) | (state == S_FIX);

endmodule

// File: tb/tb_mul_acc.sv
// tb/tb_mul_acc.sv - self-checking bench for mul_acc against a 64-bit arithmetic model.
module tb_mul_acc;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0, MULOp = 1'b0, ACCEn = 1'b0, MULSelB = 1'b0, Flush = 1'b0;
  logic [5:0]  Func = 6'h0;
  logic [31:0] A = '0, B = '0;
  logic [31:0] Result, HI, LO;
  logic        Stall;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

`ifdef MUL_RADIX4_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 34;
`endif

  localparam logic [5:0] C_MFHI = 6'h10, C_MTHI = 6'h11, C_MFLO = 6'h12, C_MTLO = 6'h13;
  localparam logic [5:0] C_MULT = 6'h18, C_MULTU = 6'h19;
  localparam logic [5:0] C_MADD = 6'h00, C_MADDU = 6'h01, C_MUL = 6'h02;
  localparam logic [5:0] C_MSUB = 6'h04, C_MSUBU = 6'h05;

  mul_acc dut (
    .clock(clock), .reset(reset), .Start(Start), .MULOp(MULOp), .ACCEn(ACCEn),
    .MULSelB(MULSelB), .Flush(Flush), .Func(Func), .A(A), .B(B),
    .Result(Result), .HI(HI), .LO(LO), .Stall(Stall)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_prod(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'b0, a});
      y = longint'({32'b0, b});
    end
    return 64'(x * y);
  endfunction

  // Holds a multiply-class op in EX until Stall drops; reports what was seen in that cycle.
  task automatic issue_mult(input logic mop, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, output int stalls,
                            output logic [31:0] res, output logic [31:0] hi, output logic [31:0] lo);
    @(negedge clock);
    Start = 1'b1; MULOp = mop; ACCEn = 1'b1; MULSelB = 1'b1; Func = f; A = a; B = b;
    stalls = 0; res = 'x; hi = 'x; lo = 'x;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!Stall) begin
        res = Result; hi = HI; lo = LO;
        break;
      end
      stalls++;
      @(negedge clock);
    end
    Start = 1'b0;
  endtask

  // Single-cycle SPECIAL-class op; Start is left high so a following op is back to back.
  task automatic move_op(input logic [5:0] f, input logic [31:0] a,
                         output logic st, output logic [31:0] res);
    @(negedge clock);
    Start = 1'b1; MULOp = 1'b0; ACCEn = 1'b1; MULSelB = 1'b0; Func = f; A = a; B = '0;
    #1;
    st = Stall; res = Result;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    vectors++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
    vectors++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
    vectors++; if (Result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", Result); end
    vectors++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall); end
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult_directed;
    int st; logic [31:0] r, h, l;
    issue_mult(1'b0, C_MULT, 32'hFFFFFFFF, 32'd7, st, r, h, l);
    vectors++; if (st !== LAT) begin errors++; $display("FAIL mult_neg_stall: got %0d want %0d", st, LAT); end
    vectors++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFF9) begin errors++; $display("FAIL mult_neg_hilo: got %h_%h want ffffffff_fffffff9", h, l); end
    vectors++; if (r !== 32'h0) begin errors++; $display("FAIL mult_neg_result: got %h want 0", r); end
    issue_mult(1'b0, C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, st, r, h, l);
    vectors++; if ({h, l} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", h, l); end
    issue_mult(1'b0, C_MULT, 32'h80000000, 32'h80000000, st, r, h, l);
    vectors++; if ({h, l} !== 64'h40000000_00000000) begin errors++; $display("FAIL mult_minint: got %h_%h want 40000000_00000000", h, l); end
    vectors++; if (st !== LAT) begin errors++; $display("FAIL mult_minint_stall: got %0d want %0d", st, LAT); end
    m_hi = 32'h40000000; m_lo = 32'h0;
  endtask

  task automatic test_moves_acc;
    int st; logic s; logic [31:0] r, h, l;
    move_op(C_MTHI, 32'h0, s, r);
    vectors++; if (s !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b want 0", s); end
    move_op(C_MTLO, 32'd10, s, r);
    vectors++; if (s !== 1'b0) begin errors++; $display("FAIL mtlo_stall: got %b want 0", s); end
    move_op(C_MFLO, 32'h0, s, r);
    vectors++; if (r !== 32'd10 || s !== 1'b0) begin errors++; $display("FAIL mflo_after_mtlo: got %h/%b want 0000000a/0", r, s); end
    move_op(6'h3F, 32'hDEADBEEF, s, r);
    vectors++; if (r !== 32'h0 || s !== 1'b0) begin errors++; $display("FAIL bad_func: got %h/%b want 0/0", r, s); end
    issue_mult(1'b1, C_MADD, 32'd3, 32'd4, st, r, h, l);
    vectors++; if ({h, l} !== 64'd22 || st !== LAT) begin errors++; $display("FAIL madd: got %h_%h/%0d want 0_00000016/%0d", h, l, st, LAT); end
    issue_mult(1'b1, C_MSUBU, 32'd30, 32'd1, st, r, h, l);
    vectors++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFF8) begin errors++; $display("FAIL msubu: got %h_%h want ffffffff_fffffff8", h, l); end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFF8;
  endtask

  task automatic test_mul3;
    int st; logic s; logic [31:0] r, h, l;
    move_op(C_MTHI, 32'h1234, s, r);
    move_op(C_MTLO, 32'h5678, s, r);
    move_op(C_MFHI, 32'h0, s, r);
    vectors++; if (r !== 32'h1234) begin errors++; $display("FAIL mfhi_after_mthi: got %h want 00001234", r); end
    issue_mult(1'b1, C_MUL, 32'hFFFFFFFD, 32'd5, st, r, h, l);
    vectors++; if (r !== 32'hFFFFFFF1) begin errors++; $display("FAIL mul3_result: got %h want fffffff1", r); end
    vectors++; if (h !== 32'h1234 || l !== 32'h5678) begin errors++; $display("FAIL mul3_hilo: got %h_%h want 00001234_00005678", h, l); end
    m_hi = 32'h1234; m_lo = 32'h5678;
  endtask

  task automatic test_flush;
    logic s; logic [31:0] r;
    move_op(C_MTHI, 32'hAAAA0001, s, r);
    move_op(C_MTLO, 32'h5555000F, s, r);
    @(negedge clock);
    Start = 1'b1; MULOp = 1'b0; MULSelB = 1'b1; Func = C_MULT; A = 32'd1234; B = 32'd5678;
    repeat (10) @(negedge clock);
    #1;
    vectors++; if (Stall !== 1'b1) begin errors++; $display("FAIL flush_busy: got %b want 1", Stall); end
    Flush = 1'b1; Start = 1'b0;
    @(negedge clock);
    Flush = 1'b0;
    #1;
    vectors++; if (Stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", Stall); end
    vectors++; if (HI !== 32'hAAAA0001 || LO !== 32'h5555000F) begin errors++; $display("FAIL flush_hilo: got %h_%h want aaaa0001_5555000f", HI, LO); end
    @(negedge clock);
    Start = 1'b1; Flush = 1'b1; Func = C_MULT; A = 32'd3; B = 32'd3;
    @(negedge clock);
    Start = 1'b0; Flush = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    vectors++; if (Stall !== 1'b0 || HI !== 32'hAAAA0001 || LO !== 32'h5555000F) begin
      errors++; $display("FAIL flush_with_start: got %b %h_%h want 0 aaaa0001_5555000f", Stall, HI, LO);
    end
    m_hi = 32'hAAAA0001; m_lo = 32'h5555000F;
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    Start = 1'b1; MULOp = 1'b0; MULSelB = 1'b1; Func = C_MULT; A = 32'hFFFF0000; B = 32'h1234;
    repeat (20) @(negedge clock);
    reset = 1'b1; Start = 1'b0;
    @(negedge clock);
    #1;
    vectors++; if (HI !== 32'h0 || LO !== 32'h0) begin errors++; $display("FAIL midreset_hilo: got %h_%h want 0_0", HI, LO); end
    vectors++; if (Stall !== 1'b0 || Result !== 32'h0) begin errors++; $display("FAIL midreset_out: got %b/%h want 0/0", Stall, Result); end
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corner[5];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFFFFFF;
    corner[3] = 32'h80000000; corner[4] = 32'h7FFFFFFF;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic test_random;
    int st, k; logic s; logic mop; logic [5:0] f; bit sgn;
    logic [31:0] a, b, r, h, l, exp_res, v;
    logic [63:0] p;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          move_op(C_MTHI, v, s, r); m_hi = v;
          move_op(C_MFHI, 32'h0, s, r);
          vectors++; if (r !== m_hi) begin errors++; $display("FAIL rnd_mfhi[%0d]: got %h want %h", i, r, m_hi); end
        end else begin
          move_op(C_MTLO, v, s, r); m_lo = v;
          move_op(C_MFLO, 32'h0, s, r);
          vectors++; if (r !== m_lo) begin errors++; $display("FAIL rnd_mflo[%0d]: got %h want %h", i, r, m_lo); end
        end
      end
      k = $urandom_range(0, 6);
      case (k)
        0: begin mop = 1'b0; f = C_MULT;  sgn = 1'b1; end
        1: begin mop = 1'b0; f = C_MULTU; sgn = 1'b0; end
        2: begin mop = 1'b1; f = C_MADD;  sgn = 1'b1; end
        3: begin mop = 1'b1; f = C_MADDU; sgn = 1'b0; end
        4: begin mop = 1'b1; f = C_MSUB;  sgn = 1'b1; end
        5: begin mop = 1'b1; f = C_MSUBU; sgn = 1'b0; end
        default: begin mop = 1'b1; f = C_MUL; sgn = 1'b1; end
      endcase
      a = pick_operand();
      b = pick_operand();
      p = ref_prod(sgn, a, b);
      exp_res = '0;
      case (k)
        0, 1: {m_hi, m_lo} = p;
        2, 3: {m_hi, m_lo} = {m_hi, m_lo} + p;
        4, 5: {m_hi, m_lo} = {m_hi, m_lo} - p;
        default: exp_res = p[31:0];
      endcase
      issue_mult(mop, f, a, b, st, r, h, l);
      vectors++; if (st !== LAT) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, st, LAT); end
      vectors++; if (r !== exp_res) begin errors++; $display("FAIL rnd_result[%0d] f=%h a=%h b=%h: got %h want %h", i, f, a, b, r, exp_res); end
      vectors++; if (h !== m_hi || l !== m_lo) begin
        errors++; $display("FAIL rnd_hilo[%0d] f=%h a=%h b=%h: got %h_%h want %h_%h", i, f, a, b, h, l, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mult_directed;
    test_moves_acc;
    test_mul3;
    test_flush;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
